// File: rtl/usb2_ep_router_pkg.sv
// usb2_ep_router_pkg: shared FSM encoding and sizing constants for the endpoint router
package usb2_ep_router_pkg;
  typedef enum logic [1:0] {IDLE, XFER_IN, XFER_OUT, DONE} state_t;
  localparam int EP_MAX = 16;
  localparam int BUF_AW_DEF = 9;
endpackage

// File: rtl/usb2_ep_router_if.sv
// usb2_ep_router_if: packet-layer transfer strobes and buffer ports facing the router
interface usb2_ep_router_if import usb2_ep_router_pkg::*; #(
  parameter int BUF_AW = BUF_AW_DEF
);
  logic              xfer_in;
  logic              xfer_out;
  logic [3:0]        xfer_endp;
  logic [3:0]        xfer_pid;
  logic              xfer_ready;
  logic [BUF_AW-1:0] buf_in_addr;
  logic [7:0]        buf_in_data;
  logic              buf_in_wren;
  logic [BUF_AW-1:0] buf_out_addr;
  logic [7:0]        buf_out_q;
  logic [9:0]        buf_out_len;
  modport master (
    output xfer_in, xfer_out, xfer_endp, xfer_pid, buf_in_addr, buf_in_data, buf_in_wren, buf_out_addr,
    input  xfer_ready, buf_out_q, buf_out_len
  );
  modport slave (
    input  xfer_in, xfer_out, xfer_endp, xfer_pid, buf_in_addr, buf_in_data, buf_in_wren, buf_out_addr,
    output xfer_ready, buf_out_q, buf_out_len
  );
endinterface

// File: rtl/usb2_ep_router_ready_latch.sv
// usb2_ep_ready_latch: per-endpoint ready edge latch with sticky missed-ready flag
module usb2_ep_ready_latch import usb2_ep_router_pkg::*; (
  input  logic phy_clk,
  input  logic reset_n,
  input  logic ready,
  input  logic clr,
  output logic latch,
  output logic missed
);
  logic ready_q, rise;
  assign rise = ready & ~ready_q;
  always_ff @(posedge phy_clk or negedge reset_n)
    if (!reset_n) begin
      ready_q <= 1'b0;
      latch   <= 1'b0;
      missed  <= 1'b0;
    end else begin
      ready_q <= ready;
      latch   <= rise | (latch & ~clr);
      missed  <= missed | (rise & latch);
    end
endmodule

// File: rtl/usb2_ep_router.sv
// usb2_ep_router: steers one packet-layer transfer at a time to the selected USB endpoint
module usb2_ep_router import usb2_ep_router_pkg::*; #(
  parameter int NUM_EP      = 4,
  parameter int BUF_AW      = BUF_AW_DEF,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     phy_clk,
  input  logic                     reset_n,
  usb2_ep_router_if.slave          bus,
  output logic [NUM_EP-1:0]        ep_xfer_in,
  output logic [NUM_EP-1:0]        ep_xfer_out,
  output logic [NUM_EP*4-1:0]      ep_xfer_pid,
  input  logic [NUM_EP-1:0]        ep_xfer_ready,
  output logic [NUM_EP*BUF_AW-1:0] ep_buf_in_addr,
  output logic [NUM_EP*8-1:0]      ep_buf_in_data,
  output logic [NUM_EP-1:0]        ep_buf_in_wren,
  output logic [NUM_EP*BUF_AW-1:0] ep_buf_out_addr,
  input  logic [NUM_EP*8-1:0]      ep_buf_out_q,
  input  logic [NUM_EP*10-1:0]     ep_buf_out_len,
  output logic                     err_bad_endp,
  output logic                     err_timeout,
  output logic [NUM_EP-1:0]        err_missed_ep_ready
);
  localparam int TW = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;
  state_t state, state_nx;
  logic in_q, out_q, in_rise, out_rise, start, busy, to_hit, endp_ok, sel_valid, dir_out;
  logic [$clog2(EP_MAX)-1:0] sel_ep;
  logic [TW-1:0] cnt;
  logic [NUM_EP-1:0] hit, latch, clr;
  assign in_rise  = bus.xfer_in & ~in_q;
  assign out_rise = bus.xfer_out & ~out_q;
  assign start    = state == IDLE && (in_rise || out_rise);
  assign busy     = state == XFER_IN || state == XFER_OUT;
  assign to_hit   = busy && cnt == TW'(TIMEOUT_CYC - 1);
  assign endp_ok  = 32'(bus.xfer_endp) < NUM_EP;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = in_rise ? XFER_IN : out_rise ? XFER_OUT : IDLE;
    else if (state == DONE) state_nx = IDLE;
    else if (to_hit || (state == XFER_IN ? !bus.xfer_in : !bus.xfer_out)) state_nx = DONE;
  end
  // Edge registers reset high so a strobe held through reset must fall and rise again.
  always_ff @(posedge phy_clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      in_q         <= 1'b1;
      out_q        <= 1'b1;
      sel_valid    <= 1'b0;
      sel_ep       <= '0;
      dir_out      <= 1'b0;
      cnt          <= '0;
      err_bad_endp <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_nx;
      in_q         <= bus.xfer_in;
      out_q        <= bus.xfer_out;
      cnt          <= busy && state_nx != DONE ? cnt + 1'b1 : '0;
      err_bad_endp <= start && !endp_ok;
      err_timeout  <= err_timeout | to_hit;
      if (start) begin
        sel_valid <= endp_ok;
        sel_ep    <= bus.xfer_endp;
        dir_out   <= !in_rise;
      end else if (state_nx == DONE) sel_valid <= 1'b0;
    end
  for (genvar e = 0; e < NUM_EP; e++) begin : g_ep
    assign hit[e] = sel_valid && sel_ep == 4'(e);
    assign clr[e] = state == DONE && dir_out && sel_ep == 4'(e);
    assign ep_xfer_in[e]                    = hit[e] && state == XFER_IN && bus.xfer_in;
    assign ep_xfer_out[e]                   = hit[e] && state == XFER_OUT && bus.xfer_out;
    assign ep_xfer_pid[e*4 +: 4]            = hit[e] ? bus.xfer_pid : '0;
    assign ep_buf_in_addr[e*BUF_AW +: BUF_AW]  = hit[e] ? bus.buf_in_addr : '0;
    assign ep_buf_in_data[e*8 +: 8]         = hit[e] ? bus.buf_in_data : '0;
    assign ep_buf_in_wren[e]                = hit[e] && bus.buf_in_wren;
    assign ep_buf_out_addr[e*BUF_AW +: BUF_AW] = hit[e] ? bus.buf_out_addr : '0;
    usb2_ep_ready_latch u_latch (
      .phy_clk(phy_clk),
      .reset_n(reset_n),
      .ready(ep_xfer_ready[e]),
      .clr(clr[e]),
      .latch(latch[e]),
      .missed(err_missed_ep_ready[e])
    );
  end
  always_comb begin
    bus.buf_out_q   = '0;
    bus.buf_out_len = '0;
    bus.xfer_ready  = 1'b0;
    for (int i = 0; i < NUM_EP; i++)
      if (hit[i]) begin
        bus.buf_out_q   = ep_buf_out_q[i*8 +: 8];
        bus.buf_out_len = ep_buf_out_len[i*10 +: 10];
        bus.xfer_ready  = latch[i];
      end
  end
endmodule

// File: tb/tb_usb2_ep_router.sv
// tb_usb2_ep_router: scoreboard bench for transfer routing, ready latches, timeout and reset
module tb_usb2_ep_router;
  typedef struct packed {
    logic [3:0]  ein;
    logic [3:0]  eout;
    logic [15:0] pid;
    logic [7:0]  q;
    logic [9:0]  len;
    logic        rdy;
  } obs_t;
  logic phy_clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0]  ep_xfer_in, ep_xfer_out, ep_xfer_ready, ep_buf_in_wren, err_missed_ep_ready;
  logic [15:0] ep_xfer_pid;
  logic [35:0] ep_buf_in_addr, ep_buf_out_addr;
  logic [31:0] ep_buf_in_data, ep_buf_out_q;
  logic [39:0] ep_buf_out_len;
  logic        err_bad_endp, err_timeout;
  int total = 0;
  int bad = 0;
  obs_t sb[$];
  usb2_ep_router_if #(.BUF_AW(9)) bus ();
  usb2_ep_router #(.NUM_EP(4), .BUF_AW(9), .TIMEOUT_CYC(16)) dut (
    .phy_clk(phy_clk),
    .reset_n(reset_n),
    .bus(bus),
    .ep_xfer_in(ep_xfer_in),
    .ep_xfer_out(ep_xfer_out),
    .ep_xfer_pid(ep_xfer_pid),
    .ep_xfer_ready(ep_xfer_ready),
    .ep_buf_in_addr(ep_buf_in_addr),
    .ep_buf_in_data(ep_buf_in_data),
    .ep_buf_in_wren(ep_buf_in_wren),
    .ep_buf_out_addr(ep_buf_out_addr),
    .ep_buf_out_q(ep_buf_out_q),
    .ep_buf_out_len(ep_buf_out_len),
    .err_bad_endp(err_bad_endp),
    .err_timeout(err_timeout),
    .err_missed_ep_ready(err_missed_ep_ready)
  );
  always #5 phy_clk = ~phy_clk;
  task automatic step();
    @(posedge phy_clk);
    #2;
  endtask
  function automatic obs_t snap();
    return {ep_xfer_in, ep_xfer_out, ep_xfer_pid, bus.buf_out_q, bus.buf_out_len, bus.xfer_ready};
  endfunction
  function automatic obs_t mk(int ep, bit din, logic [3:0] pid, bit rdy);
    obs_t o;
    o = '0;
    o.ein[ep] = din;
    o.eout[ep] = !din;
    o.pid[ep*4 +: 4] = pid;
    o.q = 8'(8'hA0 + 17*ep);
    o.len = 10'(10'h200 + 3*ep);
    o.rdy = rdy;
    return o;
  endfunction
  function automatic bit pending(bit err);
    return err ? !err_bad_endp : (ep_xfer_in | ep_xfer_out) == 4'b0;
  endfunction
  task automatic grab(input bit err, output obs_t o);
    int n = 0;
    while (pending(err) && n < 8) begin
      step();
      n++;
    end
    if (pending(err)) begin
      total++;
      bad++;
      $display("FAIL grab_timeout: no DUT response after %0d cycles (err=%0b)", n, err);
    end
    o = snap();
  endtask
  task automatic drive(input bit i, input bit o, input logic [3:0] endp, input logic [3:0] pid);
    bus.xfer_in = i;
    bus.xfer_out = o;
    bus.xfer_endp = endp;
    bus.xfer_pid = pid;
  endtask
  task automatic pulse_ready(input int ep);
    ep_xfer_ready[ep] = 1'b1;
    step();
    ep_xfer_ready[ep] = 1'b0;
    step();
  endtask
  task automatic test_reset();
    total++;
    if ({ep_xfer_in, ep_xfer_out, ep_xfer_pid, ep_buf_in_wren, err_bad_endp, err_timeout, err_missed_ep_ready,
         bus.xfer_ready, bus.buf_out_q, bus.buf_out_len} !== '0) begin
      bad++;
      $display("FAIL reset_state: in=%b out=%b pid=%h wren=%b errs=%b%b%b rdy=%b q=%h len=%h want all 0",
               ep_xfer_in, ep_xfer_out, ep_xfer_pid, ep_buf_in_wren, err_bad_endp, err_timeout,
               err_missed_ep_ready, bus.xfer_ready, bus.buf_out_q, bus.buf_out_len);
    end
  endtask
  task automatic test_ready_out();
    obs_t o, e;
    logic [35:0] ea, eo;
    logic [31:0] ed;
    ea = '0; ea[18 +: 9] = 9'h155;
    eo = '0; eo[18 +: 9] = 9'h0AA;
    ed = '0; ed[16 +: 8] = 8'h3C;
    pulse_ready(2);
    drive(0, 1, 4'd2, 4'h9);
    sb.push_back(mk(2, 0, 4'h9, 1));
    grab(0, o);
    e = sb.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL ready_out: got %h want %h", o, e); end
    total++;
    if ({ep_buf_in_addr, ep_buf_in_data, ep_buf_in_wren, ep_buf_out_addr} !== {ea, ed, 4'b0100, eo}) begin
      bad++;
      $display("FAIL buf_route: got %h %h %b %h want %h %h 0100 %h",
               ep_buf_in_addr, ep_buf_in_data, ep_buf_in_wren, ep_buf_out_addr, ea, ed, eo);
    end
    drive(0, 0, 4'd2, 4'h9);
    step();
    total++;
    if ({ep_xfer_out, bus.xfer_ready} !== 5'b0) begin
      bad++;
      $display("FAIL done_drop: out=%b rdy=%b want 0000 0", ep_xfer_out, bus.xfer_ready);
    end
    step();
    drive(1, 0, 4'd2, 4'h4);
    sb.push_back(mk(2, 1, 4'h4, 0));
    grab(0, o);
    e = sb.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL latch_cleared: got %h want %h", o, e); end
    drive(0, 0, 4'd2, 4'h4);
    step();
    step();
    total++;
    if (err_missed_ep_ready !== 4'b0) begin
      bad++;
      $display("FAIL no_missed: got %b want 0000", err_missed_ep_ready);
    end
  endtask
  task automatic test_bad_endp();
    obs_t o, e;
    drive(1, 0, 4'd7, 4'hD);
    sb.push_back('0);
    grab(1, o);
    e = sb.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL bad_endp_obs: got %h want %h", o, e); end
    total++;
    if ({ep_buf_in_addr, ep_buf_in_data, ep_buf_in_wren, ep_buf_out_addr} !== '0) begin
      bad++;
      $display("FAIL bad_endp_route: got %h %h %b %h want 0",
               ep_buf_in_addr, ep_buf_in_data, ep_buf_in_wren, ep_buf_out_addr);
    end
    step();
    total++;
    if ({err_bad_endp, ep_xfer_in} !== 5'b0) begin
      bad++;
      $display("FAIL bad_endp_pulse: err=%b in=%b want 0 0000", err_bad_endp, ep_xfer_in);
    end
    drive(0, 0, 4'd7, 4'hD);
    step();
    step();
  endtask
  task automatic test_simultaneous();
    obs_t o, e;
    drive(1, 1, 4'd1, 4'h3);
    sb.push_back(mk(1, 1, 4'h3, 0));
    grab(0, o);
    e = sb.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL simul: got %h want %h", o, e); end
    step();
    total++;
    if ({ep_xfer_in, ep_xfer_out} !== 8'b0010_0000) begin
      bad++;
      $display("FAIL simul_hold: in=%b out=%b want 0010 0000", ep_xfer_in, ep_xfer_out);
    end
    drive(0, 0, 4'd1, 4'h3);
    step();
    step();
  endtask
  task automatic test_timeout();
    obs_t o, e;
    drive(0, 1, 4'd0, 4'h1);
    sb.push_back(mk(0, 0, 4'h1, 0));
    grab(0, o);
    e = sb.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL timeout_start: got %h want %h", o, e); end
    repeat (15) step();
    total++;
    if ({ep_xfer_out, err_timeout} !== 5'b0001_0) begin
      bad++;
      $display("FAIL timeout_early: out=%b err=%b want 0001 0", ep_xfer_out, err_timeout);
    end
    step();
    total++;
    if ({ep_xfer_out, err_timeout} !== 5'b0000_1) begin
      bad++;
      $display("FAIL timeout_hit: out=%b err=%b want 0000 1", ep_xfer_out, err_timeout);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({ep_xfer_out, err_timeout} !== 5'b0000_1) begin
        bad++;
        $display("FAIL timeout_hold%0d: out=%b err=%b want 0000 1", k, ep_xfer_out, err_timeout);
      end
    end
    drive(0, 0, 4'd0, 4'h1);
    step();
  endtask
  task automatic test_missed();
    pulse_ready(0);
    total++;
    if (err_missed_ep_ready !== 4'b0000) begin
      bad++;
      $display("FAIL missed_first: got %b want 0000", err_missed_ep_ready);
    end
    pulse_ready(0);
    total++;
    if (err_missed_ep_ready !== 4'b0001) begin
      bad++;
      $display("FAIL missed_second: got %b want 0001", err_missed_ep_ready);
    end
  endtask
  task automatic test_reset_mid();
    obs_t o, e;
    drive(1, 0, 4'd3, 4'h5);
    sb.push_back(mk(3, 1, 4'h5, 0));
    grab(0, o);
    e = sb.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL rst_mid_start: got %h want %h", o, e); end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({ep_xfer_in, err_timeout, err_missed_ep_ready, bus.xfer_ready, ep_buf_in_wren} !== '0) begin
      bad++;
      $display("FAIL rst_async: in=%b tmo=%b missed=%b rdy=%b wren=%b want 0",
               ep_xfer_in, err_timeout, err_missed_ep_ready, bus.xfer_ready, ep_buf_in_wren);
    end
    #1 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (ep_xfer_in !== 4'b0) begin
        bad++;
        $display("FAIL rst_held%0d: in=%b want 0000", k, ep_xfer_in);
      end
    end
    drive(0, 0, 4'd3, 4'h5);
    step();
    drive(1, 0, 4'd3, 4'h5);
    sb.push_back(mk(3, 1, 4'h5, 0));
    grab(0, o);
    e = sb.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL rst_rearm: got %h want %h", o, e); end
    drive(0, 0, 4'd3, 4'h5);
    step();
    step();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    drive(0, 0, 4'd0, 4'h0);
    bus.buf_in_addr = 9'h155;
    bus.buf_in_data = 8'h3C;
    bus.buf_in_wren = 1'b1;
    bus.buf_out_addr = 9'h0AA;
    ep_xfer_ready = '0;
    for (int e = 0; e < 4; e++) begin
      ep_buf_out_q[e*8 +: 8] = 8'(8'hA0 + 17*e);
      ep_buf_out_len[e*10 +: 10] = 10'(10'h200 + 3*e);
    end
    #2;
    test_reset();
    #10 reset_n = 1'b1;
    repeat (3) step();
    test_ready_out();
    test_bad_endp();
    test_simultaneous();
    test_timeout();
    test_missed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
